mem_arbiter: RTL and testbench

// - Shares one unified memory port between instruction fetch (IF) and load/store (D).
// - Lets the core use a single-port memory instead of separate instruction and data memories.
// - Holds one transaction in flight; round-robin on conflict; returns responses to the owner.
// - A timeout turns a hung memory into an error response.

---
 rtl/mem_arb_pkg.sv | 26 ++
 rtl/mem_arbiter_rr_arb2.sv | 18 +
 rtl/mem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory arbiter.
// Both instruction fetch and load/store use the same request record.
package mem_arb_pkg;

    localparam int ARB_AW = 32;
    localparam int ARB_DW = 32;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT
    } arb_state_t;

    typedef enum logic {
        OWN_IF,
        OWN_D
    } owner_t;

    typedef struct packed {
        logic [ARB_AW-1:0]   addr;
        logic                we;
        logic [ARB_DW-1:0]   wdata;
        logic [ARB_DW/8-1:0] wstrb;
    } mem_req_t;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone requester wins outright,
// and on a tie the side that did not win last time is chosen.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     last_grant,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = (last_grant == OWN_D) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store,
// one transaction in flight, with a timeout that yields an error response.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = ARB_AW,
    parameter int DW      = ARB_DW,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req_valid,
    output logic          if_req_ready,
    input  logic [AW-1:0] if_addr,
    output logic          if_rsp_valid,
    output logic [DW-1:0] if_rdata,
    output logic          if_rsp_err,
    input  logic          d_req_valid,
    output logic          d_req_ready,
    input  logic [AW-1:0] d_addr,
    input  logic          d_we,
    input  logic [DW-1:0] d_wdata,
    input  logic [DW/8-1:0] d_wstrb,
    output logic          d_rsp_valid,
    output logic [DW-1:0] d_rdata,
    output logic          d_rsp_err,
    output logic          m_req_valid,
    input  logic          m_req_ready,
    output logic [AW-1:0] m_addr,
    output logic          m_we,
    output logic [DW-1:0] m_wdata,
    output logic [DW/8-1:0] m_wstrb,
    input  logic          m_rsp_valid,
    input  logic [DW-1:0] m_rdata,
    output logic          busy
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit TO_EN = (TIMEOUT > 0);
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CW-1:0] CNT_MAX = '1;

    arb_state_t    r_state;
    arb_state_t    w_next;
    owner_t        r_owner;
    owner_t        r_last;
    mem_req_t      r_req;
    logic [CW-1:0] r_cnt;
    logic          r_if_rsp_valid;
    logic          r_d_rsp_valid;
    logic [DW-1:0] r_if_rdata;
    logic [DW-1:0] r_d_rdata;
    logic          r_if_err;
    logic          r_d_err;
    logic [1:0]    w_gnt;
    logic          w_idle;
    logic          w_acc;
    logic          w_rsp;
    logic          w_to;

    rr_arb2 u_rr (
        .req        ({d_req_valid, if_req_valid}),
        .last_grant (r_last),
        .gnt        (w_gnt)
    );

    assign w_idle       = (r_state == ARB_IDLE);
    assign if_req_ready = w_idle & w_gnt[0];
    assign d_req_ready  = w_idle & w_gnt[1];
    assign w_acc        = if_req_ready | d_req_ready;
    assign w_rsp        = (r_state == ARB_WAIT) && m_rsp_valid;
    // A real response arriving on the last allowed cycle beats the timeout.
    assign w_to = (r_state == ARB_WAIT) && !m_rsp_valid
               && TO_EN && (r_cnt == TO_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ARB_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ARB_IDLE:  if (w_acc)         w_next = ARB_ISSUE;
            ARB_ISSUE: if (m_req_ready)   w_next = ARB_WAIT;
            ARB_WAIT:  if (w_rsp || w_to) w_next = ARB_IDLE;
            default:                      w_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_req   <= '0;
            r_owner <= OWN_IF;
            r_last  <= OWN_D;
        end else if (if_req_ready) begin
            r_req.addr  <= ARB_AW'(if_addr);
            r_req.we    <= 1'b0;
            r_req.wdata <= '0;
            r_req.wstrb <= '0;
            r_owner     <= OWN_IF;
            r_last      <= OWN_IF;
        end else if (d_req_ready) begin
            r_req.addr  <= ARB_AW'(d_addr);
            r_req.we    <= d_we;
            r_req.wdata <= ARB_DW'(d_wdata);
            r_req.wstrb <= (ARB_DW/8)'(d_wstrb);
            r_owner     <= OWN_D;
            r_last      <= OWN_D;
        end
    end

    // Saturating wait counter, cleared on the memory handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if ((r_state == ARB_ISSUE) && m_req_ready) begin
            r_cnt <= '0;
        end else if ((r_state == ARB_WAIT) && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_if_rsp_valid <= 1'b0;
            r_d_rsp_valid  <= 1'b0;
            r_if_rdata     <= '0;
            r_d_rdata      <= '0;
            r_if_err       <= 1'b0;
            r_d_err        <= 1'b0;
        end else begin
            r_if_rsp_valid <= 1'b0;
            r_d_rsp_valid  <= 1'b0;
            if (w_rsp || w_to) begin
                if (r_owner == OWN_IF) begin
                    r_if_rsp_valid <= 1'b1;
                    r_if_rdata     <= w_rsp ? m_rdata : '0;
                    r_if_err       <= w_to;
                end else begin
                    r_d_rsp_valid <= 1'b1;
                    r_d_rdata     <= w_rsp ? m_rdata : '0;
                    r_d_err       <= w_to;
                end
            end
        end
    end

    assign if_rsp_valid = r_if_rsp_valid;
    assign if_rdata     = r_if_rdata;
    assign if_rsp_err   = r_if_err;
    assign d_rsp_valid  = r_d_rsp_valid;
    assign d_rdata      = r_d_rdata;
    assign d_rsp_err    = r_d_err;
    assign m_req_valid  = (r_state == ARB_ISSUE);
    assign m_addr       = AW'(r_req.addr);
    assign m_we         = r_req.we;
    assign m_wdata      = DW'(r_req.wdata);
    assign m_wstrb      = (DW/8)'(r_req.wstrb);
    assign busy         = !w_idle;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a cycle table for grant/latency,
// then hand sequences for stall, timeout and reset-in-flight.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req_valid, if_req_ready, if_rsp_valid, if_rsp_err;
    logic [31:0] if_addr, if_rdata;
    logic        d_req_valid, d_req_ready, d_we, d_rsp_valid, d_rsp_err;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [3:0]  d_wstrb, m_wstrb;
    logic        m_req_valid, m_req_ready, m_we, m_rsp_valid, busy;
    logic [31:0] m_addr, m_wdata, m_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready),
        .if_addr(if_addr), .if_rsp_valid(if_rsp_valid),
        .if_rdata(if_rdata), .if_rsp_err(if_rsp_err),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready),
        .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
        .d_wstrb(d_wstrb), .d_rsp_valid(d_rsp_valid),
        .d_rdata(d_rdata), .d_rsp_err(d_rsp_err),
        .m_req_valid(m_req_valid), .m_req_ready(m_req_ready),
        .m_addr(m_addr), .m_we(m_we), .m_wdata(m_wdata),
        .m_wstrb(m_wstrb), .m_rsp_valid(m_rsp_valid),
        .m_rdata(m_rdata), .busy(busy)
    );

    typedef struct {
        logic        ifv;
        logic [31:0] ifa;
        logic        dv;
        logic [31:0] da;
        logic        mrr;
        logic        mrv;
        logic [31:0] mrd;
        logic        e_ifr;
        logic        e_dr;
        logic        e_mqv;
        logic [31:0] e_maddr;
        logic        e_ifrv;
        logic        e_drv;
        logic [31:0] e_rd;
        logic        e_busy;
    } vec_t;

    vec_t tv[$];

    function automatic void add(
        input logic ifv, input logic [31:0] ifa,
        input logic dv, input logic [31:0] da,
        input logic mrr, input logic mrv, input logic [31:0] mrd,
        input logic e_ifr, input logic e_dr, input logic e_mqv,
        input logic [31:0] e_maddr, input logic e_ifrv,
        input logic e_drv, input logic [31:0] e_rd, input logic e_busy);
        vec_t v;
        v.ifv = ifv; v.ifa = ifa; v.dv = dv; v.da = da;
        v.mrr = mrr; v.mrv = mrv; v.mrd = mrd;
        v.e_ifr = e_ifr; v.e_dr = e_dr; v.e_mqv = e_mqv;
        v.e_maddr = e_maddr; v.e_ifrv = e_ifrv; v.e_drv = e_drv;
        v.e_rd = e_rd; v.e_busy = e_busy;
        tv.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs;
        int lat;

        reset = 1'b0;
        if_req_valid = 0; if_addr = 0;
        d_req_valid = 0; d_addr = 0; d_we = 0; d_wdata = 0; d_wstrb = 0;
        m_req_ready = 0; m_rsp_valid = 0; m_rdata = 0;

        // ifv ifa dv da mrr mrv mrd | ifr dr mqv maddr ifrv drv rd busy
        // Contention from reset: IF, D, IF, D with zero-wait memory.
        add(1,'h10,1,'h20,1,1,0,          1,0,0,'h00, 0,0,0,0);
        add(1,'h10,1,'h20,1,1,0,          0,0,1,'h10, 0,0,0,1);
        add(1,'h10,1,'h20,1,1,'hA1,       0,0,0,'h10, 0,0,0,1);
        add(1,'h10,1,'h20,1,1,0,          0,1,0,'h10, 1,0,'hA1,0);
        add(1,'h10,1,'h20,1,1,0,          0,0,1,'h20, 0,0,0,1);
        add(1,'h10,1,'h20,1,1,'hB2,       0,0,0,'h20, 0,0,0,1);
        add(1,'h10,1,'h20,1,1,0,          1,0,0,'h20, 0,1,'hB2,0);
        add(1,'h10,1,'h20,1,1,0,          0,0,1,'h10, 0,0,0,1);
        add(1,'h10,1,'h20,1,1,'hC3,       0,0,0,'h10, 0,0,0,1);
        add(1,'h10,1,'h20,1,1,0,          0,1,0,'h10, 1,0,'hC3,0);
        add(0,'h10,0,'h20,1,1,0,          0,0,1,'h20, 0,0,0,1);
        add(0,'h10,0,'h20,1,1,'hD4,       0,0,0,'h20, 0,0,0,1);
        add(0,'h10,0,'h20,1,1,0,          0,0,0,'h20, 0,1,'hD4,0);
        // IF alone, memory answers 3 cycles after the handshake.
        add(1,'h100,0,0,0,0,0,            1,0,0,'h20, 0,0,0,0);
        add(0,'h100,0,0,1,0,0,            0,0,1,'h100,0,0,0,1);
        add(0,'h100,0,0,0,0,0,            0,0,0,'h100,0,0,0,1);
        add(0,'h100,0,0,0,0,0,            0,0,0,'h100,0,0,0,1);
        add(0,'h100,0,0,0,1,'hDEADBEEF,   0,0,0,'h100,0,0,0,1);
        add(0,'h100,0,0,0,0,0,            0,0,0,'h100,1,0,'hDEADBEEF,0);
        add(0,'h100,0,0,0,0,0,            0,0,0,'h100,0,0,0,0);

        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_mqv", m_req_valid, 0);
        chk("rst_maddr", m_addr, 0);
        chk("rst_ifrv", if_rsp_valid, 0);
        chk("rst_drv", d_rsp_valid, 0);
        chk("rst_ifrd", if_rdata, 0);
        chk("rst_err", {if_rsp_err, d_rsp_err}, 0);
        step();

        foreach (tv[i]) begin
            if_req_valid = tv[i].ifv; if_addr = tv[i].ifa;
            d_req_valid = tv[i].dv; d_addr = tv[i].da;
            m_req_ready = tv[i].mrr; m_rsp_valid = tv[i].mrv;
            m_rdata = tv[i].mrd;
            #1;
            chk($sformatf("v%0d_ifr", i), if_req_ready, tv[i].e_ifr);
            chk($sformatf("v%0d_dr", i), d_req_ready, tv[i].e_dr);
            chk($sformatf("v%0d_mqv", i), m_req_valid, tv[i].e_mqv);
            chk($sformatf("v%0d_maddr", i), m_addr, tv[i].e_maddr);
            chk($sformatf("v%0d_ifrv", i), if_rsp_valid, tv[i].e_ifrv);
            chk($sformatf("v%0d_drv", i), d_rsp_valid, tv[i].e_drv);
            chk($sformatf("v%0d_busy", i), busy, tv[i].e_busy);
            if (tv[i].e_ifrv) begin
                chk($sformatf("v%0d_ifrd", i), if_rdata, tv[i].e_rd);
                chk($sformatf("v%0d_iferr", i), if_rsp_err, 0);
            end
            if (tv[i].e_drv) begin
                chk($sformatf("v%0d_drd", i), d_rdata, tv[i].e_rd);
                chk($sformatf("v%0d_derr", i), d_rsp_err, 0);
            end
            step();
        end
        if_req_valid = 0; m_rsp_valid = 0; m_req_ready = 0;

        // Store held off by m_req_ready for 4 cycles.
        d_req_valid = 1; d_addr = 'h200; d_we = 1;
        d_wdata = 'h12345678; d_wstrb = 4'b0011;
        #1 chk("st_dr", d_req_ready, 1);
        step();
        d_req_valid = 0; d_addr = 'hFFFF; d_we = 0; d_wdata = 0; d_wstrb = 0;
        hs = 0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("st_mqv", m_req_valid, 1);
            chk("st_maddr", m_addr, 'h200);
            chk("st_mwe", m_we, 1);
            chk("st_mwdata", m_wdata, 'h12345678);
            chk("st_mwstrb", m_wstrb, 4'b0011);
            if (m_req_valid && m_req_ready) hs++;
            step();
        end
        m_req_ready = 1;
        #1;
        if (m_req_valid && m_req_ready) hs++;
        step();
        m_req_ready = 0;
        #1;
        chk("st_mqv_wait", m_req_valid, 0);
        chk("st_hs", hs, 1);
        step();
        m_rsp_valid = 1; m_rdata = 'h55;
        step();
        m_rsp_valid = 0;
        #1;
        chk("st_drv", d_rsp_valid, 1);
        chk("st_ifrv", if_rsp_valid, 0);
        chk("st_derr", d_rsp_err, 0);
        step();
        chk("st_pulse", d_rsp_valid, 0);

        // Memory never answers: error response 9 cycles after the handshake.
        d_req_valid = 1; d_addr = 'h300; d_we = 0; m_req_ready = 1;
        #1 chk("to_dr", d_req_ready, 1);
        step();
        d_req_valid = 0;
        #1 chk("to_mqv", m_req_valid, 1);
        step();
        m_req_ready = 0;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            #1;
            if (d_rsp_valid) begin
                lat = k;
                break;
            end
            step();
        end
        chk("to_lat", lat, 9);
        chk("to_err", d_rsp_err, 1);
        chk("to_rdata", d_rdata, 0);
        step();
        m_rsp_valid = 1; m_rdata = 'h77;
        step();
        m_rsp_valid = 0;
        #1;
        chk("late_drv", d_rsp_valid, 0);
        chk("late_ifrv", if_rsp_valid, 0);
        chk("late_rdata", d_rdata, 0);
        chk("late_err", d_rsp_err, 1);
        chk("late_busy", busy, 0);
        step();

        // Reset while waiting on memory discards the transaction.
        if_req_valid = 1; if_addr = 'h400; m_req_ready = 1;
        step();
        if_req_valid = 0;
        step();
        m_req_ready = 0;
        step();
        chk("rw_busy", busy, 1);
        #2 reset = 1'b0;
        #1;
        chk("rw_busy0", busy, 0);
        chk("rw_mqv", m_req_valid, 0);
        chk("rw_maddr", m_addr, 0);
        m_rsp_valid = 1; m_rdata = 'h99;
        step();
        step();
        chk("rw_ifrv", if_rsp_valid, 0);
        chk("rw_drv", d_rsp_valid, 0);
        chk("rw_ifrd", if_rdata, 0);
        m_rsp_valid = 0;
        reset = 1'b1;
        if_req_valid = 1; if_addr = 'h500;
        d_req_valid = 1; d_addr = 'h600;
        #1;
        chk("rr_ifr", if_req_ready, 1);
        chk("rr_dr", d_req_ready, 0);
        step();
        if_req_valid = 0; m_req_ready = 1;
        #1 chk("rr_maddr", m_addr, 'h500);
        step();
        m_req_ready = 0; m_rsp_valid = 1; m_rdata = 'hCAFE0001;
        step();
        m_rsp_valid = 0;
        #1;
        chk("rr_ifrv", if_rsp_valid, 1);
        chk("rr_ifrd", if_rdata, 'hCAFE0001);
        chk("rr_iferr", if_rsp_err, 0);
        chk("rr_drv", d_rsp_valid, 0);
        chk("rr_dr2", d_req_ready, 1);
        step();
        d_req_valid = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
